// File: rtl/int_service_fsm_pkg.sv
// Shared encodings for the interrupt service FSM: decode cause ops, IVOR indices,
// FSM states and the default vector base.
package int_service_fsm_pkg;

    localparam int INTOP_W = 2;
    localparam logic [INTOP_W-1:0] INTOp_SC   = 2'd1;
    localparam logic [INTOP_W-1:0] INTOp_TRAP = 2'd2;

    localparam logic [3:0] IVOR_EXT  = 4'd4;
    localparam logic [3:0] IVOR_TRAP = 4'd6;
    localparam logic [3:0] IVOR_SC   = 4'd8;

    localparam logic [31:0] INT_ENTRY_ADDR = 32'h0000_0100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE,
        ST_JUMP,
        ST_RFI_DRAIN,
        ST_RFI_JUMP
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE,
        CAUSE_EXT,
        CAUSE_TRAP,
        CAUSE_SC
    } cause_e;

    function automatic logic [3:0] ivor_index(input cause_e c);
        case (c)
            CAUSE_EXT:  return IVOR_EXT;
            CAUSE_TRAP: return IVOR_TRAP;
            CAUSE_SC:   return IVOR_SC;
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/int_service_fsm_vector_calc.sv
// Maps a latched interrupt cause to its vector: ENTRY_ADDR + IVOR index * 16,
// PC_WIDTH-wide with the carry dropped.
module int_vector_calc
    import int_service_fsm_pkg::*;
#(
    parameter int                  PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] ENTRY_ADDR = PC_WIDTH'(INT_ENTRY_ADDR)
) (
    input  logic [1:0]          cause,
    output logic [PC_WIDTH-1:0] vec
);

    logic [7:0] offset;

    always_comb begin
        offset = {ivor_index(cause_e'(cause)), 4'h0};
        vec    = ENTRY_ADDR + PC_WIDTH'(offset);
    end

endmodule

// File: rtl/int_service_fsm.sv
// Interrupt/rfi responder: drains the pipe, saves SRR0/SRR1, clears MSR[EE],
// acks the external latch and redirects fetch; rfi restores MSR/PC from SRR1/SRR0.
module int_service_fsm
    import int_service_fsm_pkg::*;
#(
    parameter int                  PC_WIDTH     = 32,
    parameter int                  MSR_WIDTH    = 32,
    parameter int                  EE_BIT       = 16,
    parameter int                  DRAIN_CYCLES = 3,
    parameter logic [PC_WIDTH-1:0] ENTRY_ADDR   = PC_WIDTH'(INT_ENTRY_ADDR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 intReq,
    output logic                 intAck,
    input  logic                 sync_valid,
    input  logic [INTOP_W-1:0]   sync_intOp,
    input  logic                 rfi,
    input  logic [PC_WIDTH-1:0]  pc_cur,
    input  logic [PC_WIDTH-1:0]  pc_next,
    input  logic                 pipe_empty,
    input  logic [MSR_WIDTH-1:0] msr_in,
    input  logic [PC_WIDTH-1:0]  srr0_in,
    input  logic [MSR_WIDTH-1:0] srr1_in,
    output logic                 stall,
    output logic                 flush,
    output logic                 pc_redirect,
    output logic [PC_WIDTH-1:0]  pc_target,
    output logic                 srr0_we,
    output logic [PC_WIDTH-1:0]  srr0_wd,
    output logic                 srr1_we,
    output logic [MSR_WIDTH-1:0] srr1_wd,
    output logic                 msr_we,
    output logic [MSR_WIDTH-1:0] msr_wd,
    output logic                 busy
);

    localparam int                   CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    // EE_BIT uses MSB-0 numbering
    localparam logic [MSR_WIDTH-1:0] EE_MASK  = MSR_WIDTH'(1) << (MSR_WIDTH - 1 - EE_BIT);

    state_e                state_q, state_d;
    cause_e                cause_q, cause_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_dec;
    logic [PC_WIDTH-1:0]   spc_q, spc_d;
    logic [PC_WIDTH-1:0]   vec;
    logic                  accept;

    int_vector_calc #(
        .PC_WIDTH   (PC_WIDTH),
        .ENTRY_ADDR (ENTRY_ADDR)
    ) u_vec (
        .cause (cause_q),
        .vec   (vec)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_q;
        spc_d   = spc_q;
        cnt_dec = (cnt_q == '0) ? cnt_q : cnt_q - CNT_W'(1);
        case (state_q)
            ST_IDLE: begin
                if (sync_valid) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                    if (sync_intOp == INTOp_SC) begin
                        cause_d = CAUSE_SC;
                        spc_d   = pc_next;
                    end else begin
                        cause_d = CAUSE_TRAP;
                        spc_d   = pc_cur;
                    end
                end else if (intReq) begin
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_LOAD;
                    cause_d = CAUSE_EXT;
                    spc_d   = pc_cur;
                end else if (rfi) begin
                    state_d = ST_RFI_DRAIN;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_dec;
                if (cnt_q == '0 && pipe_empty) state_d = ST_SAVE;
            end
            ST_SAVE: state_d = ST_JUMP;
            ST_JUMP: begin
                state_d = ST_IDLE;
                cause_d = CAUSE_NONE;
            end
            ST_RFI_DRAIN: begin
                cnt_d = cnt_dec;
                if (cnt_q == '0 && pipe_empty) state_d = ST_RFI_JUMP;
            end
            ST_RFI_JUMP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cause_q <= CAUSE_NONE;
            cnt_q   <= '0;
            spc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            spc_q   <= spc_d;
        end
    end

    assign accept = (state_q == ST_IDLE) && (sync_valid || intReq || rfi);

    // Outputs are suppressed while rst is high so a reset landing in SAVE/JUMP
    // never leaks an SPR write or redirect.
    always_comb begin
        stall       = 1'b0;
        flush       = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        srr0_we     = 1'b0;
        srr0_wd     = '0;
        srr1_we     = 1'b0;
        srr1_wd     = '0;
        msr_we      = 1'b0;
        msr_wd      = '0;
        intAck      = 1'b0;
        busy        = 1'b0;
        if (!rst) begin
            busy = (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    stall = accept;
                    flush = accept;
                end
                ST_DRAIN, ST_RFI_DRAIN: stall = 1'b1;
                ST_SAVE: begin
                    stall   = 1'b1;
                    srr0_we = 1'b1;
                    srr0_wd = spc_q;
                    srr1_we = 1'b1;
                    srr1_wd = msr_in;
                    msr_we  = 1'b1;
                    msr_wd  = msr_in & ~EE_MASK;
                    intAck  = (cause_q == CAUSE_EXT);
                end
                ST_JUMP: begin
                    pc_redirect = 1'b1;
                    pc_target   = vec;
                end
                ST_RFI_JUMP: begin
                    msr_we      = 1'b1;
                    msr_wd      = srr1_in;
                    pc_redirect = 1'b1;
                    pc_target   = srr0_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_service_fsm.sv
// Randomized bench for int_service_fsm against a per-transaction timeline model.
module tb_int_service_fsm;
    import int_service_fsm_pkg::*;

    localparam int          DC    = 3;
    localparam logic [31:0] ENTRY = 32'hFFFF_FFA0;
    localparam int K_EXT = 0, K_SC = 1, K_TRAP = 2, K_RFI = 3;

    typedef struct packed {
        logic        busy, stall, flush, redir, ack, s0we, s1we, mwe;
        logic [31:0] tgt, s0wd, s1wd, mwd;
    } out_t;

    logic        clk, rst;
    logic        intReq, intAck, sync_valid, rfi, pipe_empty;
    logic [1:0]  sync_intOp;
    logic [31:0] pc_cur, pc_next, msr_in, srr0_in, srr1_in;
    logic        stall, flush, pc_redirect, srr0_we, srr1_we, msr_we, busy;
    logic [31:0] pc_target, srr0_wd, srr1_wd, msr_wd;

    int ncmp = 0;
    int nfail = 0;

    int_service_fsm #(
        .PC_WIDTH(32), .MSR_WIDTH(32), .EE_BIT(16), .DRAIN_CYCLES(DC), .ENTRY_ADDR(ENTRY)
    ) dut (
        .clk(clk), .rst(rst), .intReq(intReq), .intAck(intAck),
        .sync_valid(sync_valid), .sync_intOp(sync_intOp), .rfi(rfi),
        .pc_cur(pc_cur), .pc_next(pc_next), .pipe_empty(pipe_empty),
        .msr_in(msr_in), .srr0_in(srr0_in), .srr1_in(srr1_in),
        .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .srr0_we(srr0_we), .srr0_wd(srr0_wd), .srr1_we(srr1_we), .srr1_wd(srr1_wd),
        .msr_we(msr_we), .msr_wd(msr_wd), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t obs();
        out_t o;
        o = '{busy, stall, flush, pc_redirect, intAck, srr0_we, srr1_we, msr_we,
              pc_target, srr0_wd, srr1_wd, msr_wd};
        return o;
    endfunction

    // Expected outputs k cycles after acceptance; d is the last drain cycle.
    function automatic out_t model(input int kind, input int k, input int d,
                                   input logic [31:0] pcc, msr, s0, s1);
        out_t e;
        e = '0;
        if (k == 0) begin
            e.stall = 1'b1;
            e.flush = 1'b1;
            return e;
        end
        e.busy = 1'b1;
        if (k <= d) begin
            e.stall = 1'b1;
        end else if (kind == K_RFI) begin
            e.mwe = 1'b1; e.mwd = s1; e.redir = 1'b1; e.tgt = s0;
        end else if (k == d + 1) begin
            e.stall = 1'b1;
            e.s0we  = 1'b1; e.s0wd = (kind == K_SC) ? pcc + 32'd4 : pcc;
            e.s1we  = 1'b1; e.s1wd = msr;
            e.mwe   = 1'b1; e.mwd  = msr & ~32'h0000_8000;
            e.ack   = (kind == K_EXT);
        end else begin
            e.redir = 1'b1;
            e.tgt   = ENTRY + ((kind == K_EXT) ? 32'h40 : (kind == K_TRAP) ? 32'h60 : 32'h80);
        end
        return e;
    endfunction

    // Drives one transaction cycle by cycle; pipe_empty is low for lo cycles after
    // acceptance. Inputs outside IDLE are randomized to show they are ignored.
    task automatic run_seq(input string nm, input int kind, input logic [31:0] pcc, msr, s0, s1,
                           input int lo, input int rst_at, input bit req_hi);
        int d, last;
        out_t e, o;
        d    = (DC > lo + 1) ? DC : lo + 1;
        last = (kind == K_RFI) ? d + 1 : d + 2;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            pc_cur = pcc; pc_next = pcc + 32'd4; msr_in = msr; srr0_in = s0; srr1_in = s1;
            pipe_empty = (k == 0) ? 1'($urandom_range(0, 1)) : (k > lo);
            sync_intOp = 2'($urandom_range(0, 3));
            if (k == 0) begin
                sync_valid = (kind == K_SC || kind == K_TRAP);
                if (kind == K_SC) sync_intOp = INTOp_SC;
                else if (kind == K_TRAP) sync_intOp = INTOp_TRAP;
                intReq = (kind == K_EXT) || req_hi ||
                         (kind != K_RFI && $urandom_range(0, 1) == 1);
                rfi    = (kind == K_RFI) || ($urandom_range(0, 1) == 1);
            end else begin
                sync_valid = 1'($urandom_range(0, 1));
                rfi        = 1'($urandom_range(0, 1));
                intReq     = (kind == K_EXT) ? (k <= d + 1) : 1'($urandom_range(0, 1));
            end
            rst = (k == rst_at);
            #1;
            e = (k == rst_at) ? '0 : model(kind, k, d, pcc, msr, s0, s1);
            o = obs();
            ncmp++;
            if (o !== e) begin
                nfail++;
                $display("FAIL %s cyc%0d: got %h want %h", nm, k, o, e);
            end
            if (k == rst_at) begin
                @(negedge clk);
                rst = 1'b0; sync_valid = 1'b0; intReq = 1'b0; rfi = 1'b0;
                #1;
                o = obs();
                ncmp++;
                if (o !== '0) begin
                    nfail++;
                    $display("FAIL %s after_rst: got %h want %h", nm, o, out_t'('0));
                end
                return;
            end
        end
    endtask

    task automatic idle_gap(input string nm);
        out_t o;
        @(negedge clk);
        rst = 1'b0; sync_valid = 1'b0; intReq = 1'b0; rfi = 1'b0;
        pipe_empty = 1'($urandom_range(0, 1));
        #1;
        o = obs();
        ncmp++;
        if (o !== '0) begin
            nfail++;
            $display("FAIL %s idle: got %h want %h", nm, o, out_t'('0));
        end
    endtask

    task automatic test_reset();
        out_t o;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            rst = 1'b1; sync_valid = 1'b1; intReq = 1'b1; rfi = 1'b1; pipe_empty = 1'b1;
            #1;
            o = obs();
            ncmp++;
            if (o !== '0) begin
                nfail++;
                $display("FAIL reset_hold cyc%0d: got %h want %h", i, o, out_t'('0));
            end
        end
        idle_gap("reset_release");
    endtask

    task automatic test_ext();
        run_seq("ext", K_EXT, 32'h100, 32'h8000, 32'h0, 32'h0, 0, -1, 1'b0);
        idle_gap("ext");
    endtask

    task automatic test_sc();
        run_seq("sc", K_SC, 32'h200, 32'h8000, 32'h0, 32'h0, 1, -1, 1'b0);
        idle_gap("sc");
        run_seq("sc_wrap", K_SC, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, -1, 1'b0);
        idle_gap("sc_wrap");
    endtask

    task automatic test_rfi_drain();
        run_seq("rfi_drain", K_RFI, 32'h500, 32'h0, 32'h404, 32'h8000, 5, -1, 1'b0);
        idle_gap("rfi_drain");
    endtask

    // TRAP wins over a pending intReq; rfi restores EE and the held request is
    // taken the very cycle after RFI_JUMP.
    task automatic test_back_to_back();
        run_seq("trap_prio", K_TRAP, 32'h300, 32'h8000, 32'h0, 32'h0, 0, -1, 1'b1);
        run_seq("b2b_rfi", K_RFI, 32'h600, 32'h0, 32'h304, 32'h8000, 2, -1, 1'b0);
        run_seq("b2b_ext", K_EXT, 32'h304, 32'h8000, 32'h0, 32'h0, 0, -1, 1'b0);
        idle_gap("b2b");
    endtask

    task automatic test_reset_mid();
        run_seq("rst_save", K_EXT, 32'h700, 32'h8000, 32'h0, 32'h0, 0, DC + 1, 1'b0);
        run_seq("rst_drain", K_SC, 32'h800, 32'h8000, 32'h0, 32'h0, 0, 2, 1'b0);
        run_seq("rst_rfijump", K_RFI, 32'h900, 32'h0, 32'h404, 32'h8000, 0, DC + 1, 1'b0);
    endtask

    task automatic test_random();
        int kind;
        logic [31:0] pcc;
        for (int i = 0; i < 24; i++) begin
            kind = $urandom_range(0, 3);
            pcc  = $urandom() & 32'hFFFF_FFFC;
            if (i % 7 == 3) pcc = 32'hFFFF_FFFC;
            run_seq("random", kind, pcc, $urandom(), $urandom(), $urandom(),
                    $urandom_range(0, 6), -1, 1'b0);
            if ($urandom_range(0, 1) == 1) idle_gap("random");
        end
    endtask

    initial begin
        rst = 1'b1; intReq = 1'b0; sync_valid = 1'b0; sync_intOp = '0; rfi = 1'b0;
        pipe_empty = 1'b0; pc_cur = '0; pc_next = '0; msr_in = '0; srr0_in = '0; srr1_in = '0;
        test_reset();
        test_ext();
        test_sc();
        test_rfi_drain();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
